inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning queue depth in instructions; legal values are 2 and 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  discard queue and redirect fetch to flush_pc.
REQ-005 SHALL have port flush_pc  input  8  new fetch address, sampled when flush=1.
REQ-006 SHALL have port mem_req  output  1  memory read request, registered.
REQ-007 SHALL have port mem_addr  output  8  byte address for the current request, registered.
REQ-008 SHALL have port mem_ready  input  1  mem_data valid while mem_req=1.
REQ-009 SHALL have port mem_data  input  8  read byte.
REQ-010 SHALL have port inst_out  output  16  queue head instruction.
REQ-011 SHALL have port inst_pc  output  8  byte address of the queue head instruction.
REQ-012 SHALL have port inst_valid  output  1  queue not empty.
REQ-013 SHALL have port inst_take  input  1  consumer pops the head on this edge.

Function
REQ-014 SHALL implement FSM states IDLE, RD_HI, GAP, RD_LO.
REQ-015 SHALL hold mem_req=0 in IDLE and move to RD_HI when count<DEPTH and flush=0.
REQ-016 SHALL drive mem_req=1, mem_addr=fpc in RD_HI and, on mem_ready=1, capture mem_data as inst[15:8] and move to GAP.
REQ-017 SHALL drive mem_req=0 for exactly one cycle in GAP, then move to RD_LO.
REQ-018 SHALL drive mem_req=1, mem_addr=fpc+1 (mod 256) in RD_LO and, on mem_ready=1, capture mem_data as inst[7:0].
REQ-019 SHALL, on the same RD_LO capture edge, push {hi,lo} with pc=fpc, set fpc=fpc+2 (mod 256), and return to IDLE.
REQ-020 SHALL keep mem_req low for at least one cycle in IDLE between instructions.
REQ-021 SHALL hold mem_req and mem_addr stable in RD_HI and RD_LO until mem_ready=1, with no timeout.
REQ-022 SHALL derive inst_valid=(count!=0), with inst_out and inst_pc taken directly from head registers and no combinational path from mem_data.
REQ-023 SHALL pop the head on an edge with inst_take=1 and inst_valid=1.
REQ-024 SHALL ignore inst_take while the queue is empty.
REQ-025 SHALL leave count unchanged when a push and a pop occur on the same edge.
REQ-026 SHALL never let count exceed DEPTH; a fetch starts only when count<DEPTH.
REQ-027 SHALL, on flush=1, on the next edge: clear the queue, set fpc=flush_pc, drop mem_req, enter IDLE, and discard any captured hi byte or same-edge mem_data.
REQ-028 SHALL give flush priority over a simultaneous push or pop.
REQ-029 SHALL not issue a new request on the edge that services a flush.
REQ-030 SHALL use queue pointers that wrap modulo DEPTH.

Reset
REQ-031 SHALL, while rst=1, force: state=IDLE, fpc=0x00, count=0, pointers=0, mem_req=0, mem_addr=0x00, inst_out=0x0000, inst_pc=0x00, inst_valid=0.
REQ-032 SHALL, on rst asserted mid-read, drop mem_req immediately (asynchronously) and discard any partial instruction.
REQ-033 SHALL, after rst deasserts, begin fetching from 0x00 from IDLE.

Configuration
REQ-034 SHALL, with macro PREFETCH_STATS_EN defined, add output stall_cnt (8 bits): increments on each cycle with inst_take=1 and inst_valid=0, saturates at 0xFF, and is cleared by rst but not by flush.
REQ-035 SHALL, with PREFETCH_STATS_EN undefined, omit the stall_cnt port and all its logic.

Verification
(Memory model: asserts mem_ready 2 cycles after mem_req rises and holds it while mem_req=1.)
REQ-036 SHALL cover: reset release, mem[0..3]=12,34,56,78, no take -> reads at 0x00, then 0x01, then 0x02, then 0x03; inst_out=0x1234 with inst_pc=0x00; count reaches 2; mem_req then stays 0.
REQ-037 SHALL cover: queue full, inst_take held 1 -> instructions pop in order 0x1234, 0x5678, with fetch resuming at 0x04 one cycle after the first pop.
REQ-038 SHALL cover: flush=1 with flush_pc=0x40 while in GAP after the hi byte -> queue empty, next read at 0x40, first instruction has inst_pc=0x40.
REQ-039 SHALL cover: flush_pc=0xFE -> reads at 0xFE and 0xFF, then 0x00 and 0x01; inst_pc sequence is 0xFE, then 0x00.
REQ-040 SHALL cover: rst pulse while mem_req=1 in RD_LO -> mem_req falls before the next edge, and all outputs take reset values.
REQ-041 SHALL cover, with PREFETCH_STATS_EN: inst_take=1 for 300 cycles with mem_ready tied 0 -> stall_cnt=0xFF.

Source files
------------

// File: rtl/inst_prefetch.sv
// Two-byte instruction prefetcher: each instruction takes two byte reads (hi, then lo), separated
// by a dead cycle. Results go into a small queue. Optional stall counter under PREFETCH_STATS_EN.
module inst_prefetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  flush_pc,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic [15:0] inst_out,
    output logic [7:0]  inst_pc,
    output logic        inst_valid,
    input  logic        inst_take
`ifdef PREFETCH_STATS_EN
    ,
    output logic [7:0]  stall_cnt
`endif
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRdHi, StGap, StRdLo} state_t;

    state_t          state_q, state_d;
    logic [7:0]      fpc_q, fpc_d;
    logic [7:0]      hi_q, hi_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]     q_inst_q [DEPTH];
    logic [7:0]      q_pc_q   [DEPTH];
    logic            mem_req_d;
    logic [7:0]      mem_addr_d;
    logic            push, pop;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        hi_d       = hi_q;
        push       = 1'b0;
        unique case (state_q)
            StIdle: if (!flush && count_q < CW'(DEPTH)) state_d = StRdHi;
            StRdHi: begin
                if (mem_ready) begin
                    hi_d    = mem_data;
                    state_d = StGap;
                end
            end
            StGap:  state_d = StRdLo;
            StRdLo: begin
                if (mem_ready) begin
                    push    = 1'b1;
                    fpc_d   = fpc_q + 8'd2;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush wins over any capture, push or pop on the same edge.
        if (flush) begin
            state_d = StIdle;
            fpc_d   = flush_pc;
            push    = 1'b0;
        end
        pop = inst_take && (count_q != '0) && !flush;

        mem_req_d  = (state_d == StRdHi) || (state_d == StRdLo);
        mem_addr_d = mem_addr;
        if (state_d == StRdHi) mem_addr_d = fpc_d;
        if (state_d == StRdLo) mem_addr_d = fpc_d + 8'd1;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            fpc_q    <= 8'h00;
            hi_q     <= 8'h00;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_req  <= 1'b0;
            mem_addr <= 8'h00;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            hi_q     <= hi_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_req  <= mem_req_d;
            mem_addr <= mem_addr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_inst_q[i] <= 16'h0000;
                q_pc_q[i]   <= 8'h00;
            end
        end else if (push) begin
            q_inst_q[wr_ptr_q] <= {hi_q, mem_data};
            q_pc_q[wr_ptr_q]   <= fpc_q;
        end
    end

    // Head outputs come straight from queue registers; no path from mem_data.
    assign inst_valid = (count_q != '0);
    assign inst_out   = q_inst_q[rd_ptr_q];
    assign inst_pc    = q_pc_q[rd_ptr_q];

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 8'h00;
        end else if (inst_take && !inst_valid && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: byte memory with 2-cycle ready, an instruction-queue reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_inst_prefetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, flush, mem_req, mem_ready, inst_valid, inst_take;
    logic [7:0]  flush_pc, mem_addr, mem_data, inst_pc;
    logic [15:0] inst_out;
`ifdef PREFETCH_STATS_EN
    logic [7:0]  stall_cnt;
`endif

    inst_prefetch #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_take  (inst_take)
`ifdef PREFETCH_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Memory: ready two cycles after the request rises, held while requested.
    logic [7:0] mem [256];
    logic       ready_en;
    int         age = 0;
    always @(posedge clk) age <= mem_req ? age + 1 : 0;
    assign mem_ready = mem_req && (age >= 2) && ready_en;
    assign mem_data  = mem[mem_addr];

    // Reference model: queue of {pc, inst}; fetch pointer and byte phase.
    typedef struct {
        logic [7:0]  pc;
        logic [15:0] inst;
    } ent_t;
    ent_t       mq[$];
    logic [7:0] mfpc = 8'h00;
    logic [7:0] mhi = 8'h00;
    bit         beat = 1'b0;
    bit         last_req = 1'b0;
    logic [7:0] addr_log[$];

    always @(posedge clk) begin : model
        bit         hs, fl;
        int         sz_pre;
        logic [7:0] ea;
        hs = 1'b0;
        fl = 1'b0;
        sz_pre = mq.size();
        if (rst) begin
            mq.delete();
            mfpc = 8'h00;
            beat = 1'b0;
        end else begin
            fl = flush;
            hs = mem_req && mem_ready;
            if (fl) begin
                mq.delete();
                mfpc = flush_pc;
                beat = 1'b0;
            end else begin
                if (inst_take && sz_pre > 0) void'(mq.pop_front());
                if (hs) begin
                    if (!beat) begin
                        mhi  = mem_data;
                        beat = 1'b1;
                    end else begin
                        mq.push_back('{pc: mfpc, inst: {mhi, mem_data}});
                        mfpc = mfpc + 8'd2;
                        beat = 1'b0;
                    end
                end
            end
        end
        #1;
        if (rst) begin
            check("rst_valid", {31'd0, inst_valid}, 32'd0);
            check("rst_req", {31'd0, mem_req}, 32'd0);
        end else begin
            check("valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("inst_out", {16'd0, inst_out}, {16'd0, mq[0].inst});
                check("inst_pc", {24'd0, inst_pc}, {24'd0, mq[0].pc});
            end
            ea = beat ? mfpc + 8'd1 : mfpc;
            if (hs || fl) check("req_gap", {31'd0, mem_req}, 32'd0);
            else if (mem_req) check("mem_addr", {24'd0, mem_addr}, {24'd0, ea});
            if (mem_req && !last_req && !beat) check("start_room", {31'd0, sz_pre < DEPTH}, 32'd1);
            check("depth", {31'd0, mq.size() <= DEPTH}, 32'd1);
        end
        if (mem_req && !last_req) addr_log.push_back(mem_addr);
        last_req = mem_req;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
        check({tag, "_out"}, {16'd0, inst_out}, 32'd0);
        check({tag, "_pc"}, {24'd0, inst_pc}, 32'd0);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = 8'h00; inst_take = 1'b0; ready_en = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
        mem[8'h40] = 8'hAB; mem[8'h41] = 8'hCD; mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Fill with no consumer: four byte reads, then fetch stops with the queue full.
        for (int i = 0; i < 200 && addr_log.size() < 4; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check("fill_reads", addr_log.size(), 32'd4);
        if (addr_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("fill_addr", {24'd0, addr_log[i]}, i);
        end
        check("fill_out", {16'd0, inst_out}, 32'h1234);
        check("fill_pc", {24'd0, inst_pc}, 32'h00);
        check("fill_idle", {31'd0, mem_req}, 32'd0);

        // Drain in order; fetch restarts at 0x04 one cycle after the first pop.
        inst_take = 1'b1;
        @(posedge clk); #1;
        check("pop1_out", {16'd0, inst_out}, 32'h5678);
        check("pop1_pc", {24'd0, inst_pc}, 32'h02);
        check("pop1_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        check("resume_req", {31'd0, mem_req}, 32'd1);
        check("resume_addr", {24'd0, mem_addr}, 32'h04);
        check("pop2_empty", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        inst_take = 1'b0;

        // Flush during the gap after the hi byte.
        for (int i = 0; i < 100 && !(!mem_req && mem_addr == 8'h04); i++) @(negedge clk);
        check("gap_reached", {31'd0, !mem_req && mem_addr == 8'h04}, 32'd1);
        flush = 1'b1; flush_pc = 8'h40; addr_log.delete();
        @(negedge clk);
        flush = 1'b0;
        check("flush_empty", {31'd0, inst_valid}, 32'd0);
        check("flush_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 100 && !inst_valid; i++) @(negedge clk);
        check("flush_addr", (addr_log.size() > 0) ? {24'd0, addr_log[0]} : 32'hFFFF, 32'h40);
        check("flush_pc", {24'd0, inst_pc}, 32'h40);
        check("flush_out", {16'd0, inst_out}, 32'hABCD);

        // Fetch address wraps past 0xFF.
        flush = 1'b1; flush_pc = 8'hFE; addr_log.delete();
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 100 && !inst_valid; i++) @(negedge clk);
        check("wrap_pc0", {24'd0, inst_pc}, 32'hFE);
        check("wrap_out0", {16'd0, inst_out}, 32'h1122);
        inst_take = 1'b1;
        @(negedge clk);
        inst_take = 1'b0;
        for (int i = 0; i < 100 && !inst_valid; i++) @(negedge clk);
        check("wrap_pc1", {24'd0, inst_pc}, 32'h00);
        check("wrap_out1", {16'd0, inst_out}, 32'h1234);
        check("wrap_reads", {31'd0, addr_log.size() >= 4}, 32'd1);
        if (addr_log.size() >= 4) begin
            check("wrap_a0", {24'd0, addr_log[0]}, 32'hFE);
            check("wrap_a1", {24'd0, addr_log[1]}, 32'hFF);
            check("wrap_a2", {24'd0, addr_log[2]}, 32'h00);
            check("wrap_a3", {24'd0, addr_log[3]}, 32'h01);
        end

        // Asynchronous reset during the lo-byte read.
        for (int i = 0; i < 100 && !(mem_req && mem_addr[0]); i++) @(negedge clk);
        check("rdlo_reached", {31'd0, mem_req && mem_addr[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        addr_log.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50 && addr_log.size() == 0; i++) @(negedge clk);
        check("post_rst_addr", (addr_log.size() > 0) ? {24'd0, addr_log[0]} : 32'hFFFF, 32'h00);

`ifdef PREFETCH_STATS_EN
        rst = 1'b1; ready_en = 1'b0;
        @(negedge clk);
        check("stall_rst", {24'd0, stall_cnt}, 32'd0);
        rst = 1'b0; inst_take = 1'b1;
        repeat (10) @(negedge clk);
        check("stall_10", {24'd0, stall_cnt}, 32'd10);
        repeat (290) @(negedge clk);
        check("stall_sat", {24'd0, stall_cnt}, 32'hFF);
        inst_take = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
